imm_decode_stage: RTL and testbench

- Registered decode slice between instruction fetch and execute. Classifies each incoming RV32I instruction by opcode, drives the immediate unit with the matching immediate select, and presents the immediate, PC and instruction to execute.
- Valid/ready handshake on both sides. A 2-entry skid buffer gives full throughput with registered o_Ready.
- Pipeline flush input for branch/jump redirects.

---
 rtl/imm_decode_stage_pkg.sv | 51 +++++
 rtl/imm_decode_stage_if.sv | 35 +++
 rtl/imm_decode_stage_immediate_unit.sv | 29 ++
 rtl/imm_decode_stage.sv | 107 ++++++++++
 tb/tb_imm_decode_stage.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/imm_decode_stage_pkg.sv
// imm_decode_stage_pkg
//   Shared widths, immediate-select encodings and RV32I opcode constants
//   for the decode stage and the control decoder.
package imm_decode_stage_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned IMM_SEL_WIDTH = 2;

    // Immediate select; the bus is [IMM_SEL_WIDTH:0].
    typedef enum logic [IMM_SEL_WIDTH:0] {
        IMM_U_TYPE       = 3'd0,
        IMM_J_TYPE       = 3'd1,
        IMM_I_TYPE       = 3'd2,
        IMM_S_TYPE       = 3'd3,
        IMM_B_TYPE       = 3'd4,
        IMM_UNKNOWN_TYPE = 3'd7
    } imm_sel_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // One buffered decode entry (output register or skid slot).
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        imm_sel_e        sel;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    function automatic imm_sel_e opcode_to_sel(input logic [6:0] opcode);
        imm_sel_e sel;
        case (opcode)
            OP_LUI, OP_AUIPC:                      sel = IMM_U_TYPE;
            OP_JAL:                                sel = IMM_J_TYPE;
            OP_JALR, OP_LOAD, OP_OP_IMM, OP_SYSTEM: sel = IMM_I_TYPE;
            OP_STORE:                              sel = IMM_S_TYPE;
            OP_BRANCH:                             sel = IMM_B_TYPE;
            default:                               sel = IMM_UNKNOWN_TYPE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// imm_decode_stage_if
//   Upstream (fetch) and downstream (execute) handshake/data signals of the
//   decode stage.
//   slave  : view of the decode stage itself.
//   master : view of the surrounding pipeline (fetch + execute).
interface imm_decode_stage_if;
    import imm_decode_stage_pkg::*;

    // Upstream side
    logic                   i_Valid;
    logic                   o_Ready;
    logic [XLEN-1:0]        i_Instruction;
    logic [XLEN-1:0]        i_PC;
    // Downstream side
    logic                   o_Valid;
    logic                   i_Ready;
    logic [XLEN-1:0]        o_Instruction;
    logic [XLEN-1:0]        o_PC;
    logic [IMM_SEL_WIDTH:0] o_Imm_Select;
    logic [XLEN-1:0]        o_Immediate;
    logic                   o_Illegal;

    modport slave (
        input  i_Valid, i_Instruction, i_PC, i_Ready,
        output o_Ready, o_Valid, o_Instruction, o_PC,
               o_Imm_Select, o_Immediate, o_Illegal
    );

    modport master (
        output i_Valid, i_Instruction, i_PC, i_Ready,
        input  o_Ready, o_Valid, o_Instruction, o_PC,
               o_Imm_Select, o_Immediate, o_Illegal
    );

endinterface

// File: rtl/imm_decode_stage_immediate_unit.sv
// immediate_unit
//   Combinational RV32I immediate generator.
//   i_Instr_Bits : instruction bits [31:7]
//   i_Imm_Select : immediate type
//   o_Immediate  : sign-extended immediate (0 for unknown type)
module immediate_unit
    import imm_decode_stage_pkg::*;
(
    input  logic [31:7]     i_Instr_Bits,
    input  imm_sel_e        i_Imm_Select,
    output logic [XLEN-1:0] o_Immediate
);

    logic [31:7] b;
    assign b = i_Instr_Bits;

    always_comb begin
        o_Immediate = '0;
        case (i_Imm_Select)
            IMM_U_TYPE: o_Immediate = {b[31:12], 12'b0};
            IMM_J_TYPE: o_Immediate = {{12{b[31]}}, b[19:12], b[20], b[30:21], 1'b0};
            IMM_I_TYPE: o_Immediate = {{21{b[31]}}, b[30:20]};
            IMM_S_TYPE: o_Immediate = {{21{b[31]}}, b[30:25], b[11:7]};
            IMM_B_TYPE: o_Immediate = {{20{b[31]}}, b[7], b[30:25], b[11:8], 1'b0};
            default:    o_Immediate = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Registered decode slice between fetch and execute. Decodes the immediate
//   type from the opcode, generates the immediate, and buffers instruction,
//   PC, select, immediate and illegal flag in an output register backed by a
//   one-entry skid slot so o_Ready can be registered at full throughput.
//   i_Clock   : clock, rising edge
//   i_Reset_N : synchronous active-low reset
//   i_Flush   : drop all buffered entries and any same-cycle input
//   bus       : valid/ready upstream and downstream (imm_decode_stage_if)
module imm_decode_stage
    import imm_decode_stage_pkg::*;
(
    input  logic               i_Clock,
    input  logic               i_Reset_N,
    input  logic               i_Flush,
    imm_decode_stage_if.slave  bus
);

    imm_sel_e        dec_sel;
    logic [XLEN-1:0] dec_imm;
    entry_t          in_entry;

    entry_t out_q,        out_d;
    entry_t skid_q,       skid_d;
    logic   out_valid_q,  out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   ready_q,      ready_d;

    logic in_xfer;
    logic out_xfer;

    always_comb begin
        dec_sel = opcode_to_sel(bus.i_Instruction[6:0]);
    end

    immediate_unit u_immediate_unit (
        .i_Instr_Bits (bus.i_Instruction[31:7]),
        .i_Imm_Select (dec_sel),
        .o_Immediate  (dec_imm)
    );

    always_comb begin
        in_entry.instr   = bus.i_Instruction;
        in_entry.pc      = bus.i_PC;
        in_entry.sel     = dec_sel;
        in_entry.imm     = dec_imm;
        in_entry.illegal = (dec_sel == IMM_UNKNOWN_TYPE);
    end

    assign in_xfer  = bus.i_Valid & ready_q;
    assign out_xfer = out_valid_q & bus.i_Ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (i_Flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_xfer) begin
            // Skid has priority so ordering stays FIFO; in_xfer cannot
            // coincide with a full skid because ready_q is low then.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                out_d       = in_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            out_q         <= '0;
            out_q.sel     <= IMM_UNKNOWN_TYPE;
            skid_q        <= '0;
            skid_q.sel    <= IMM_UNKNOWN_TYPE;
            out_valid_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            out_q         <= out_d;
            skid_q        <= skid_d;
            out_valid_q   <= out_valid_d;
            skid_valid_q  <= skid_valid_d;
            ready_q       <= ready_d;
        end
    end

    assign bus.o_Ready       = ready_q;
    assign bus.o_Valid       = out_valid_q;
    assign bus.o_Instruction = out_q.instr;
    assign bus.o_PC          = out_q.pc;
    assign bus.o_Imm_Select  = out_q.sel;
    assign bus.o_Immediate   = out_q.imm;
    assign bus.o_Illegal     = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage
//   Directed bench for imm_decode_stage: reset, streaming, decode types,
//   backpressure through the skid slot, illegal opcode, flush, mid-stream reset.
module tb_imm_decode_stage;
    import imm_decode_stage_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;

    int unsigned vectors;
    int unsigned miscompares;

    imm_decode_stage_if bus ();

    imm_decode_stage dut (
        .i_Clock   (clk),
        .i_Reset_N (rst_n),
        .i_Flush   (flush),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.i_Valid       = v;
        bus.i_Instruction = instr;
        bus.i_PC          = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; bus.i_Ready = 1'b0;
        drive(1'b1, 32'h0000_0013, 32'h0000_0000);
        tick(); tick();
        vectors++; if (bus.o_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.o_Valid); end
        vectors++; if (bus.o_Ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", bus.o_Ready); end
        vectors++; if (bus.o_Imm_Select !== 3'd7) begin miscompares++; $display("FAIL reset_sel got=%0d exp=7", bus.o_Imm_Select); end
        vectors++; if (bus.o_Illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got=%b exp=0", bus.o_Illegal); end
        vectors++; if (bus.o_Immediate !== 32'h0 || bus.o_Instruction !== 32'h0 || bus.o_PC !== 32'h0) begin
            miscompares++; $display("FAIL reset_data got imm=%h instr=%h pc=%h exp=0", bus.o_Immediate, bus.o_Instruction, bus.o_PC); end
        drive(1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();
        vectors++; if (bus.o_Valid !== 1'b0 || bus.o_Ready !== 1'b1) begin
            miscompares++; $display("FAIL post_reset_idle got valid=%b ready=%b exp valid=0 ready=1", bus.o_Valid, bus.o_Ready); end
    endtask

    task automatic test_stream();
        bus.i_Ready = 1'b1;
        drive(1'b1, 32'h1234_50B7, 32'h0000_0100);
        tick();
        vectors++; if (bus.o_Valid !== 1'b1 || bus.o_Immediate !== 32'h1234_5000 || bus.o_Imm_Select !== 3'd0) begin
            miscompares++; $display("FAIL stream_lui got v=%b imm=%h sel=%0d exp v=1 imm=12345000 sel=0", bus.o_Valid, bus.o_Immediate, bus.o_Imm_Select); end
        vectors++; if (bus.o_PC !== 32'h100 || bus.o_Instruction !== 32'h1234_50B7 || bus.o_Ready !== 1'b1) begin
            miscompares++; $display("FAIL stream_lui_meta got pc=%h instr=%h rdy=%b", bus.o_PC, bus.o_Instruction, bus.o_Ready); end
        drive(1'b1, 32'hFFF0_0093, 32'h0000_0104);
        tick();
        vectors++; if (bus.o_Valid !== 1'b1 || bus.o_Immediate !== 32'hFFFF_FFFF || bus.o_Imm_Select !== 3'd2 || bus.o_PC !== 32'h104) begin
            miscompares++; $display("FAIL stream_addi got v=%b imm=%h sel=%0d pc=%h exp v=1 imm=ffffffff sel=2 pc=104", bus.o_Valid, bus.o_Immediate, bus.o_Imm_Select, bus.o_PC); end
        vectors++; if (bus.o_Ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready got=%b exp=1", bus.o_Ready); end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        vectors++; if (bus.o_Valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got=%b exp=0", bus.o_Valid); end
    endtask

    task automatic test_decode_types();
        logic [31:0] instrs [3] = '{32'hFE00_0EE3, 32'h0011_2623, 32'h0100_006F};
        logic [31:0] imms   [3] = '{32'hFFFF_FFFC, 32'h0000_000C, 32'h0000_0010};
        logic [2:0]  sels   [3] = '{3'd4, 3'd3, 3'd1};
        bus.i_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, instrs[i], 32'h300 + 32'(4 * i));
            tick();
            vectors++; if (bus.o_Valid !== 1'b1 || bus.o_Imm_Select !== sels[i] || bus.o_Immediate !== imms[i] || bus.o_Illegal !== 1'b0) begin
                miscompares++; $display("FAIL decode_%0d got v=%b sel=%0d imm=%h ill=%b exp v=1 sel=%0d imm=%h ill=0",
                                        i, bus.o_Valid, bus.o_Imm_Select, bus.o_Immediate, bus.o_Illegal, sels[i], imms[i]); end
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_illegal();
        bus.i_Ready = 1'b1;
        drive(1'b1, 32'h0000_007F, 32'h0000_0400);
        tick();
        vectors++; if (bus.o_Valid !== 1'b1 || bus.o_Illegal !== 1'b1 || bus.o_Imm_Select !== 3'd7 || bus.o_Immediate !== 32'h0) begin
            miscompares++; $display("FAIL illegal got v=%b ill=%b sel=%0d imm=%h exp v=1 ill=1 sel=7 imm=0",
                                    bus.o_Valid, bus.o_Illegal, bus.o_Imm_Select, bus.o_Immediate); end
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_backpressure();
        bus.i_Ready = 1'b0;
        drive(1'b1, 32'h0050_0093, 32'h0000_0200);   // A: addi imm 5
        tick();
        vectors++; if (bus.o_Valid !== 1'b1 || bus.o_Immediate !== 32'd5 || bus.o_Ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_first got v=%b imm=%h rdy=%b exp v=1 imm=5 rdy=1", bus.o_Valid, bus.o_Immediate, bus.o_Ready); end
        drive(1'b1, 32'h00A0_0113, 32'h0000_0204);   // B: addi imm 10
        tick();
        vectors++; if (bus.o_Ready !== 1'b0 || bus.o_PC !== 32'h200 || bus.o_Immediate !== 32'd5) begin
            miscompares++; $display("FAIL bp_skid_full got rdy=%b pc=%h imm=%h exp rdy=0 pc=200 imm=5", bus.o_Ready, bus.o_PC, bus.o_Immediate); end
        drive(1'b1, 32'h00F0_0193, 32'h0000_0208);   // C: addi imm 15, refused
        tick();
        vectors++; if (bus.o_Ready !== 1'b0 || bus.o_Valid !== 1'b1 || bus.o_PC !== 32'h200 || bus.o_Instruction !== 32'h0050_0093) begin
            miscompares++; $display("FAIL bp_stable got rdy=%b v=%b pc=%h instr=%h exp rdy=0 v=1 pc=200 instr=00500093",
                                    bus.o_Ready, bus.o_Valid, bus.o_PC, bus.o_Instruction); end
        bus.i_Ready = 1'b1;
        tick();
        vectors++; if (bus.o_Valid !== 1'b1 || bus.o_PC !== 32'h204 || bus.o_Immediate !== 32'd10 || bus.o_Ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_drain_b got v=%b pc=%h imm=%h rdy=%b exp v=1 pc=204 imm=a rdy=1",
                                    bus.o_Valid, bus.o_PC, bus.o_Immediate, bus.o_Ready); end
        tick();
        vectors++; if (bus.o_Valid !== 1'b1 || bus.o_PC !== 32'h208 || bus.o_Immediate !== 32'd15) begin
            miscompares++; $display("FAIL bp_third got v=%b pc=%h imm=%h exp v=1 pc=208 imm=f", bus.o_Valid, bus.o_PC, bus.o_Immediate); end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        vectors++; if (bus.o_Valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got=%b exp=0", bus.o_Valid); end
    endtask

    task automatic test_flush();
        bus.i_Ready = 1'b0;
        drive(1'b1, 32'h0050_0093, 32'h0000_0500);
        tick();
        drive(1'b1, 32'h00A0_0113, 32'h0000_0504);
        tick();
        vectors++; if (bus.o_Ready !== 1'b0) begin miscompares++; $display("FAIL flush_setup_ready got=%b exp=0", bus.o_Ready); end
        flush = 1'b1;
        drive(1'b1, 32'h00F0_0193, 32'h0000_0508);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        vectors++; if (bus.o_Valid !== 1'b0 || bus.o_Ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", bus.o_Valid, bus.o_Ready); end
        bus.i_Ready = 1'b1;
        tick(); tick();
        vectors++; if (bus.o_Valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_ghost got=%b exp=0", bus.o_Valid); end
        // Flush while ready=1 and empty: the offered input is still dropped.
        flush = 1'b1;
        drive(1'b1, 32'h1234_50B7, 32'h0000_050C);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        vectors++; if (bus.o_Valid !== 1'b0 || bus.o_Ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_empty got v=%b rdy=%b exp v=0 rdy=1", bus.o_Valid, bus.o_Ready); end
    endtask

    task automatic test_reset_midstream();
        bus.i_Ready = 1'b0;
        drive(1'b1, 32'h0050_0093, 32'h0000_0600);
        tick();
        drive(1'b1, 32'h00A0_0113, 32'h0000_0604);
        tick();
        rst_n = 1'b0;
        tick();
        vectors++; if (bus.o_Valid !== 1'b0 || bus.o_Ready !== 1'b1 || bus.o_Imm_Select !== 3'd7) begin
            miscompares++; $display("FAIL midreset got v=%b rdy=%b sel=%0d exp v=0 rdy=1 sel=7", bus.o_Valid, bus.o_Ready, bus.o_Imm_Select); end
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        bus.i_Ready = 1'b1;
        tick();
        vectors++; if (bus.o_Valid !== 1'b0 || bus.o_Ready !== 1'b1) begin
            miscompares++; $display("FAIL midreset_idle got v=%b rdy=%b exp v=0 rdy=1", bus.o_Valid, bus.o_Ready); end
        drive(1'b1, 32'h0100_006F, 32'h0000_0700);
        tick();
        vectors++; if (bus.o_Valid !== 1'b1 || bus.o_Immediate !== 32'h10 || bus.o_Imm_Select !== 3'd1 || bus.o_PC !== 32'h700) begin
            miscompares++; $display("FAIL midreset_restream got v=%b imm=%h sel=%0d pc=%h exp v=1 imm=10 sel=1 pc=700",
                                    bus.o_Valid, bus.o_Immediate, bus.o_Imm_Select, bus.o_PC); end
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.i_Ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        test_reset();
        test_stream();
        test_decode_types();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
